// File: rtl/branch_pkg.sv
// Branch-control encodings shared by the branch-select translator and the
// PC sequencer, plus immediate extraction helpers.
package branch_pkg;

  localparam logic [1:0] BRANCH_NEVER        = 2'b00;
  localparam logic [1:0] BRANCH_ALU_NON_ZERO = 2'b01;
  localparam logic [1:0] BRANCH_ALU_ZERO     = 2'b10;
  localparam logic [1:0] BRANCH_ALWAYS       = 2'b11;

  localparam logic [2:0] BRANCH_SRC_ZERO     = 3'b000;
  localparam logic [2:0] BRANCH_SRC_PC_PLUS4 = 3'b001;
  localparam logic [2:0] BRANCH_SRC_PC       = 3'b010;
  localparam logic [2:0] BRANCH_SRC_REG      = 3'b011;
  localparam logic [2:0] BRANCH_SRC_IMM_I    = 3'b100;
  localparam logic [2:0] BRANCH_SRC_IMM_J    = 3'b101;
  localparam logic [2:0] BRANCH_SRC_IMM_B    = 3'b110;
  localparam logic [2:0] BRANCH_SRC_ZERO_ALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_HALT
  } seq_state_e;

  typedef struct packed {
    logic [31:0] next_pc;
    logic        taken;
    logic        misaligned;
  } branch_res_t;

  function automatic logic [31:0] imm_i(logic [31:7] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_j(logic [31:7] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(logic [31:7] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC logic: operand select, target add, taken
// evaluation and alignment check.
module branch_target_calc (
  input  logic [31:0] pc_i,
  input  logic [31:7] instr_i,
  input  logic [1:0]  op_i,
  input  logic [2:0]  base_src_i,
  input  logic [2:0]  offset_src_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] next_pc_o,
  output logic        taken_o,
  output logic        misaligned_o
);
  import branch_pkg::*;

  logic [31:0] pc_plus4;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] sum;
  logic [31:0] target;
  logic        alu_zero;

  function automatic logic [31:0] operand(
    logic [2:0]  sel,
    logic [31:0] pc,
    logic [31:0] pc4,
    logic [31:0] rs1,
    logic [31:7] ir
  );
    logic [31:0] v;
    v = '0;
    case (sel)
      BRANCH_SRC_ZERO:     v = '0;
      BRANCH_SRC_PC_PLUS4: v = pc4;
      BRANCH_SRC_PC:       v = pc;
      BRANCH_SRC_REG:      v = rs1;
      BRANCH_SRC_IMM_I:    v = imm_i(ir);
      BRANCH_SRC_IMM_J:    v = imm_j(ir);
      BRANCH_SRC_IMM_B:    v = imm_b(ir);
      BRANCH_SRC_ZERO_ALT: v = '0;
      default:             v = '0;
    endcase
    return v;
  endfunction

  assign pc_plus4 = pc_i + 32'd4;
  assign base     = operand(base_src_i, pc_i, pc_plus4, rs1_i, instr_i);
  assign offset   = operand(offset_src_i, pc_i, pc_plus4, rs1_i, instr_i);
  assign sum      = base + offset;

  // Register-relative jumps drop bit 0 of the sum
  assign target = (base_src_i == BRANCH_SRC_REG) ?
                  {sum[31:1], 1'b0} : sum;

  assign alu_zero = (alu_result_i == 32'd0);

  always_comb begin
    taken_o = 1'b0;
    unique case (op_i)
      BRANCH_NEVER:        taken_o = 1'b0;
      BRANCH_ALU_NON_ZERO: taken_o = !alu_zero;
      BRANCH_ALU_ZERO:     taken_o = alu_zero;
      BRANCH_ALWAYS:       taken_o = 1'b1;
      default:             taken_o = 1'b0;
    endcase
  end

  assign misaligned_o = taken_o && (target[1:0] != 2'b00);
  assign next_pc_o    = taken_o ? target : pc_plus4;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC: fetches over a valid/ready port, holds the
// instruction for execute, then steps or branches on completion.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_req_valid,
  output logic [31:0] fetch_req_addr,
  input  logic        fetch_req_ready,
  input  logic        fetch_resp_valid,
  input  logic [31:0] fetch_resp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  branch_op,
  input  logic [2:0]  branch_base_src,
  input  logic [2:0]  branch_offset_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap_misaligned
);
  import branch_pkg::*;

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        trap_q, trap_d;
  branch_res_t br;

  branch_target_calc u_calc (
    .pc_i         (pc_q),
    .instr_i      (instr_q[31:7]),
    .op_i         (branch_op),
    .base_src_i   (branch_base_src),
    .offset_src_i (branch_offset_src),
    .alu_result_i (alu_result),
    .rs1_i        (rs1_data),
    .next_pc_o    (br.next_pc),
    .taken_o      (br.taken),
    .misaligned_o (br.misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    trap_d  = trap_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (fetch_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fetch_resp_valid) begin
          instr_d = fetch_resp_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          // A misaligned taken target freezes pc at the faulting branch
          if (br.misaligned) begin
            trap_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = br.next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end

  assign fetch_req_valid = (state_q == ST_FETCH);
  assign fetch_req_addr  = pc_q;
  assign instr           = instr_q;
  assign instr_valid     = (state_q == ST_EXEC);
  assign pc              = pc_q;
  assign pc_plus4        = pc_q + 32'd4;
  assign trap_misaligned = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against an in-bench
// transaction-level model of the fetch/execute loop.
module tb_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_EXEC  = 3;
  localparam int PH_HALT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_addr;
  logic        fetch_req_ready;
  logic        fetch_resp_valid;
  logic [31:0] fetch_resp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  branch_op;
  logic [2:0]  branch_base_src;
  logic [2:0]  branch_offset_src;
  logic [31:0] alu_result;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap_misaligned;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  int          m_ph;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_trap;
  logic [31:0] exec_pp4;

  pc_sequencer #(.RESET_PC(RPC)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_req_valid   (fetch_req_valid),
    .fetch_req_addr    (fetch_req_addr),
    .fetch_req_ready   (fetch_req_ready),
    .fetch_resp_valid  (fetch_resp_valid),
    .fetch_resp_data   (fetch_resp_data),
    .instr             (instr),
    .instr_valid       (instr_valid),
    .exec_done         (exec_done),
    .branch_op         (branch_op),
    .branch_base_src   (branch_base_src),
    .branch_offset_src (branch_offset_src),
    .alu_result        (alu_result),
    .rs1_data          (rs1_data),
    .pc                (pc),
    .pc_plus4          (pc_plus4),
    .trap_misaligned   (trap_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_val(input logic [2:0] s,
                                          input logic [31:0] p,
                                          input logic [31:0] ir,
                                          input logic [31:0] r);
    int v;
    v = 0;
    if (s == 3'd1) v = int'(p) + 4;
    else if (s == 3'd2) v = int'(p);
    else if (s == 3'd3) v = int'(r);
    else if (s == 3'd4)
      v = int'(ir[31:20]) - (ir[31] ? 4096 : 0);
    else if (s == 3'd5)
      v = int'(ir[30:21]) * 2 + int'(ir[20]) * 2048
        + int'(ir[19:12]) * 4096 - (ir[31] ? 1048576 : 0);
    else if (s == 3'd6)
      v = int'(ir[11:8]) * 2 + int'(ir[30:25]) * 32
        + int'(ir[7]) * 2048 - (ir[31] ? 4096 : 0);
    return v;
  endfunction

  // Reference model: one transaction phase per step
  always @(posedge clk) begin
    logic [31:0] t;
    logic tk;
    if (reset) begin
      m_ph = PH_IDLE; m_pc = RPC; m_instr = 0; m_trap = 0;
    end else if (m_ph == PH_IDLE) begin
      m_ph = PH_FETCH;
    end else if (m_ph == PH_FETCH) begin
      if (fetch_req_ready) m_ph = PH_WAIT;
    end else if (m_ph == PH_WAIT) begin
      if (fetch_resp_valid) begin
        m_instr = fetch_resp_data; m_ph = PH_EXEC;
      end
    end else if (m_ph == PH_EXEC && exec_done) begin
      t = src_val(branch_base_src, m_pc, m_instr, rs1_data)
        + src_val(branch_offset_src, m_pc, m_instr, rs1_data);
      if (branch_base_src == 3'd3) t = t - 32'(t[0]);
      tk = (branch_op == 2'd3) ||
           (branch_op == 2'd1 && alu_result != 0) ||
           (branch_op == 2'd2 && alu_result == 0);
      if (tk && (t % 4) != 0) begin
        m_trap = 1; m_ph = PH_HALT;
      end else begin
        m_pc = tk ? t : m_pc + 4; m_ph = PH_FETCH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (fetch_req_valid !== (m_ph == PH_FETCH) ||
          fetch_req_addr !== m_pc || pc !== m_pc ||
          pc_plus4 !== m_pc + 32'd4 ||
          instr_valid !== (m_ph == PH_EXEC) ||
          instr !== m_instr || trap_misaligned !== m_trap) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got v=%b a=%h iv=%b i=%h pc=%h p4=%h tr=%b exp v=%b a=%h iv=%b i=%h tr=%b",
                 $time, fetch_req_valid, fetch_req_addr, instr_valid,
                 instr, pc, pc_plus4, trap_misaligned,
                 m_ph == PH_FETCH, m_pc, m_ph == PH_EXEC, m_instr, m_trap);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [31:0] d, input logic [1:0] op,
                           input logic [2:0] bs, input logic [2:0] os,
                           input logic [31:0] alu, input logic [31:0] r1);
    for (int i = 0; i < 8 && !fetch_req_valid; i++) step();
    if (!fetch_req_valid) begin
      chk("fetch_wait_timeout", 32'(fetch_req_valid), 32'd1);
      return;
    end
    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready  = 1'b0;
    fetch_resp_valid = 1'b1;
    fetch_resp_data  = d;
    step();
    exec_pp4 = pc_plus4;
    fetch_resp_valid  = 1'b0;
    branch_op         = op;
    branch_base_src   = bs;
    branch_offset_src = os;
    alu_result        = alu;
    rs1_data          = r1;
    exec_done         = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;

  initial begin
    reset = 1'b1;
    fetch_req_ready = 0; fetch_resp_valid = 0; fetch_resp_data = 0;
    exec_done = 0; branch_op = 0; branch_base_src = 0;
    branch_offset_src = 0; alu_result = 0; rs1_data = 0;
    step();
    chk_en = 1'b1;
    step(); step();
    chk("rst_req_valid", 32'(fetch_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_trap", 32'(trap_misaligned), 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'd0);
    reset = 1'b0;
    step();
    chk("first_req_valid", 32'(fetch_req_valid), 32'd1);
    chk("first_req_addr", fetch_req_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(fetch_req_valid), 32'd1);
      chk("stall_addr", fetch_req_addr, 32'h100);
    end
    run_instr(32'h0000_0013, 2'b00, 3'b000, 3'b000, 32'd0, 32'd0);
    chk("nop_next_addr", fetch_req_addr, 32'h104);
    chk("nop_next_valid", 32'(fetch_req_valid), 32'd1);

    run_instr(32'h2000_0013, 2'b11, 3'b000, 3'b100, 32'd0, 32'd0);
    chk("jump_200", pc, 32'h200);
    run_instr(BEQ_M8, 2'b10, 3'b010, 3'b110, 32'd0, 32'd0);
    chk("beq_taken", pc, 32'h1F8);
    run_instr(32'h2000_0013, 2'b11, 3'b000, 3'b100, 32'd0, 32'd0);
    run_instr(BEQ_M8, 2'b10, 3'b010, 3'b110, 32'd5, 32'd0);
    chk("beq_not_taken", pc, 32'h204);

    run_instr(32'h0040_0067, 2'b11, 3'b011, 3'b100, 32'd0, 32'h1003);
    chk("jalr_trap", 32'(trap_misaligned), 32'd1);
    chk("jalr_pc_held", pc, 32'h204);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_no_req", 32'(fetch_req_valid), 32'd0);
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("trap_cleared", 32'(trap_misaligned), 32'd0);
    run_instr(32'h4000_0013, 2'b11, 3'b000, 3'b100, 32'd0, 32'd0);
    chk("jump_400", pc, 32'h400);
    run_instr(32'h0010_006F, 2'b11, 3'b010, 3'b101, 32'd0, 32'd0);
    chk("jal_pc_plus4", exec_pp4, 32'h404);
    chk("jal_target", pc, 32'hC00);

    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_resp_valid = 1'b1;
    fetch_resp_data  = 32'hDEAD_BEEF;
    step();
    chk("stale_instr_valid", 32'(instr_valid), 32'd0);
    chk("stale_req_addr", fetch_req_addr, RPC);
    step();
    chk("stale_instr", instr, 32'd0);
    chk("stale_req_valid", 32'(fetch_req_valid), 32'd1);
    fetch_resp_valid = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      reset = m_trap || ($urandom_range(99) == 0);
      fetch_req_ready   = $urandom_range(1);
      fetch_resp_valid  = $urandom_range(1);
      fetch_resp_data   = $urandom;
      exec_done         = ($urandom_range(9) < 4);
      branch_op         = 2'($urandom_range(3));
      branch_base_src   = 3'($urandom_range(7));
      branch_offset_src = 3'($urandom_range(7));
      alu_result        = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      rs1_data          = $urandom;
      if ($urandom_range(1) == 1) begin
        rs1_data[1:0] = 2'b00;
        fetch_resp_data[21:20] = 2'b00;
        fetch_resp_data[9:8] = 2'b00;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
